wb_rr_arbiter: RTL

Two-master, single-slave-port Wishbone (classic, non-pipelined) arbiter placed in front of the shared conbus slave side, so the CPU bridge (master 0) and a second master such as a DMA/VGA fetch engine (master 1) can share the memory/peripheral bus. Grants are round-robin with ownership locked for a whole transaction. A watchdog terminates hung transfers with an error strobe so a missing slave ack cannot stall the CPU.

---
 rtl/wb_rr_arbiter_if.sv | 26 ++
 rtl/wb_rr_arbiter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/wb_rr_arbiter_if.sv
// One Wishbone classic link: the master drives the request side, the slave drives the response side.
// The arbiter takes three of these: two as a slave (the masters) and one as a master (the shared slave).
interface wb_rr_arbiter_if #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int SW = DW / 8
);
    logic [DW-1:0] dat_w;   // master -> slave write data
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic          we;
    logic          stb;
    logic [DW-1:0] dat_r;   // slave -> master read data
    logic          ack;
    logic          err;

    modport master (
        output dat_w, adr, sel, we, stb,
        input  dat_r, ack, err
    );

    modport slave (
        input  dat_w, adr, sel, we, stb,
        output dat_r, ack, err
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with transaction-locked grants
// and a watchdog that ends a hung transfer with a one-cycle error to its owner.
module wb_rr_arbiter #(
    parameter int DW      = 32,
    parameter int AW      = 32,
    parameter int SW      = DW / 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    wb_rr_arbiter_if.slave    m0,
    wb_rr_arbiter_if.slave    m1,
    wb_rr_arbiter_if.master   s,
    output logic [1:0]        gnt,
    output logic              timeout_flag
);

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WDOG_LAST = WDW'(TIMEOUT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [1:0]     gnt_q, gnt_d;
    logic           last_q, last_d;     // index of the master that owned the bus last
    logic [WDW-1:0] wdog_q, wdog_d;
    logic           tflag_q, tflag_d;

    logic [1:0]     req;
    logic           busy;
    logic           owner_stb;
    logic           deadline;

    assign req       = {m1.stb, m0.stb};
    assign busy      = (state_q == BUSY);
    assign owner_stb = |(gnt_q & req);
    // An abort or an ack on the final cycle wins over the timeout.
    assign deadline  = busy && owner_stb && !s.ack && (wdog_q == WDOG_LAST);

    // ------------------------------------------------------------------
    // Request routing toward the slave, selected by the registered grant
    // ------------------------------------------------------------------
    logic [DW-1:0] r_dat;
    logic [AW-1:0] r_adr;
    logic [SW-1:0] r_sel;
    logic          r_we;

    always_comb begin
        r_dat = '0;
        r_adr = '0;
        r_sel = '0;
        r_we  = 1'b0;
        if (gnt_q[1]) begin
            r_dat = m1.dat_w;
            r_adr = m1.adr;
            r_sel = m1.sel;
            r_we  = m1.we;
        end else if (gnt_q[0]) begin
            r_dat = m0.dat_w;
            r_adr = m0.adr;
            r_sel = m0.sel;
            r_we  = m0.we;
        end
    end

    assign s.dat_w = r_dat;
    assign s.adr   = r_adr;
    assign s.sel   = r_sel;
    assign s.we    = r_we;
    assign s.stb   = busy & owner_stb & ~deadline;

    // Response path: data is broadcast, ack/err only reach the owner.
    assign m0.dat_r = s.dat_r;
    assign m1.dat_r = s.dat_r;
    assign m0.ack   = busy & gnt_q[0] & s.ack;
    assign m1.ack   = busy & gnt_q[1] & s.ack;
    assign m0.err   = gnt_q[0] & deadline;
    assign m1.err   = gnt_q[1] & deadline;

    assign gnt          = gnt_q;
    assign timeout_flag = tflag_q;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        wdog_d  = wdog_q;
        tflag_d = tflag_q;

        case (state_q)
            IDLE: begin
                if (req != 2'b00) begin
                    state_d = BUSY;
                    wdog_d  = '0;
                    if (req == 2'b11)
                        gnt_d = last_q ? 2'b01 : 2'b10;
                    else
                        gnt_d = req;
                end
            end
            BUSY: begin
                if (s.ack || !owner_stb || deadline) begin
                    state_d = IDLE;
                    gnt_d   = 2'b00;
                    wdog_d  = '0;
                    last_d  = gnt_q[1];
                    if (deadline)
                        tflag_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 2'b00;
                wdog_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 2'b00;
            last_q  <= 1'b1;
            wdog_q  <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
            wdog_q  <= wdog_d;
            tflag_q <= tflag_d;
        end
    end

endmodule
